alarme: RTL and testbench

ALARME -- requirements
Module: alarme

---
 rtl/alarme.sv | 123 ++++++++++++
 tb/tb_alarme.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/alarme.sv
// Intrusion alarm: synchronized arm/sensor/ack inputs, debounced trigger FSM, saturating alarm-entry counter.
// Build option ALARME_LATCH_EN: alarm latches until acknowledged with both sensors clear.
module alarme #(
    parameter int DEBOUNCE = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       A,
    input  logic       B,
    input  logic       C,
    input  logic       ACK,
    output logic       Y,
    output logic [7:0] ALM_CNT
);

    typedef enum logic [1:0] {IDLE, ARMED, PENDING, ALARM} state_t;

    localparam logic [7:0] DEB_LAST = 8'(DEBOUNCE);

    logic [3:0] pins;
    logic [3:0] sync_meta_reg;
    logic [3:0] sync_s_reg;
    logic       a_s, b_s, c_s, ack_s;
    logic       cond;
    logic       exit_alarm;

    state_t     state_reg, state_next;
    logic [7:0] cnt_reg, cnt_next;
    logic       y_reg;
    logic [7:0] alm_cnt_reg;
    logic       alarm_entry;

    assign pins = {A, B, C, ACK};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_meta_reg <= '0;
            sync_s_reg    <= '0;
        end else begin
            sync_meta_reg <= pins;
            sync_s_reg    <= sync_meta_reg;
        end
    end

    assign {a_s, b_s, c_s, ack_s} = sync_s_reg;
    assign cond = a_s & (b_s | c_s);

`ifdef ALARME_LATCH_EN
    // An acknowledge only counts once both sensors have gone quiet.
    assign exit_alarm = ack_s & ~b_s & ~c_s;
`else
    assign exit_alarm = ~cond;
`endif

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            IDLE: begin
                cnt_next = '0;
                if (a_s) state_next = ARMED;
            end
            ARMED: begin
                cnt_next = '0;
                if (!a_s) begin
                    state_next = IDLE;
                end else if (cond) begin
                    state_next = PENDING;
                    cnt_next   = 8'd1;
                end
            end
            PENDING: begin
                if (!a_s) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end else if (!cond) begin
                    state_next = ARMED;
                    cnt_next   = '0;
                end else if (cnt_reg == DEB_LAST) begin
                    state_next = ALARM;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_reg + 8'd1;
                end
            end
            ALARM: begin
                cnt_next = '0;
                // Disarm takes priority over every other exit.
                if (!a_s) begin
                    state_next = IDLE;
                end else if (exit_alarm) begin
                    state_next = ARMED;
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    assign alarm_entry = (state_next == ALARM) && (state_reg != ALARM);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= IDLE;
            cnt_reg     <= '0;
            y_reg       <= 1'b0;
            alm_cnt_reg <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            y_reg     <= (state_next == ALARM);
            if (alarm_entry && (alm_cnt_reg != 8'hFF)) begin
                alm_cnt_reg <= alm_cnt_reg + 8'd1;
            end
        end
    end

    assign Y       = y_reg;
    assign ALM_CNT = alm_cnt_reg;

endmodule

// File: tb/tb_alarme.sv
// Bench for alarme: random and directed stimulus checked every cycle against a run-length model of the alarm rules.
// Build with or without ALARME_LATCH_EN to match the design under test.
module tb_alarme;

    localparam int DEB = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       A = 1'b0, B = 1'b0, C = 1'b0, ACK = 1'b0;
    logic       Y;
    logic [7:0] ALM_CNT;

    int tests = 0;
    int fails = 0;

    // Model: pins seen through a two-stage delay, plus the length of the current trigger run.
    bit [3:0] m_s1, m_s2;
    int       run_len;
    bit       run_pre_armed;
    bit       last_as;
    bit       y_m;
    int       cnt_m;

    alarme #(.DEBOUNCE(DEB)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .A      (A),
        .B      (B),
        .C      (C),
        .ACK    (ACK),
        .Y      (Y),
        .ALM_CNT(ALM_CNT)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_s1 = '0; m_s2 = '0;
        run_len = 0; run_pre_armed = 1'b0; last_as = 1'b0;
        y_m = 1'b0; cnt_m = 0;
    endtask

    // Alarm is reached once the trigger has held DEB+1 consecutive edges starting from an armed
    // system, or DEB+2 edges when arming itself happens on the run's first edge.
    task automatic model_edge();
        bit as_, bs, cs, acks, cond, new_y;
        int thr;
        {as_, bs, cs, acks} = m_s2;
        cond = as_ & (bs | cs);
        if (cond) begin
            if (run_len == 0) run_pre_armed = last_as;
            if (run_len < 1000) run_len++;
        end else begin
            run_len = 0;
        end
        thr = DEB + 1 + (run_pre_armed ? 0 : 1);
`ifdef ALARME_LATCH_EN
        if (y_m) new_y = as_ && !(acks && !bs && !cs);
        else     new_y = cond && (run_len >= thr);
`else
        new_y = cond && (run_len >= thr);
`endif
        if (new_y && !y_m && cnt_m < 255) cnt_m++;
        y_m = new_y;
        last_as = as_;
        m_s2 = m_s1;
        m_s1 = {A, B, C, ACK};
    endtask

    task automatic check(input string name, input int actual, input int expected);
        tests++;
        if (actual !== expected) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    // One clock edge: advance the model, then compare DUT against it just after the edge.
    task automatic step();
        @(posedge clk);
        if (!rst_n) model_reset();
        else        model_edge();
        #1;
        check("y_model", int'(Y), int'(y_m));
        check("cnt_model", int'(ALM_CNT), cnt_m);
    endtask

    task automatic hold(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check("reset_y", int'(Y), 0);
        check("reset_cnt", int'(ALM_CNT), 0);
        hold(3);
        rst_n = 1'b1;

        // Arm first; B then changes right after "edge 0" and Y must rise exactly at edge 7.
        A = 1'b1;
        hold(5);
        B = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            step();
            check($sformatf("latency_edge%0d", k), int'(Y), (k == 7) ? 1 : 0);
        end
        check("first_entry_cnt", int'(ALM_CNT), 1);

        B = 1'b0; ACK = 1'b1;
        hold(6);
        check("cleared_y", int'(Y), 0);
        ACK = 1'b0;
        hold(4);

        // Three-cycle pulse is shorter than the debounce window.
        B = 1'b1;
        hold(3);
        B = 1'b0;
        for (int k = 0; k < 12; k++) begin
            step();
            check("short_pulse_y", int'(Y), 0);
        end
        check("short_pulse_cnt", int'(ALM_CNT), 1);

        B = 1'b1;
        hold(8);
        check("alarm2_y", int'(Y), 1);
        check("alarm2_cnt", int'(ALM_CNT), 2);
        B = 1'b0;
`ifdef ALARME_LATCH_EN
        hold(10);
        check("latched_hold_y", int'(Y), 1);
        ACK = 1'b1;
`endif
        for (int k = 1; k <= 3; k++) begin
            step();
            check($sformatf("release_edge%0d", k), int'(Y), (k == 3) ? 0 : 1);
        end
        ACK = 1'b0;
        hold(3);

        // Disarm during alarm drops Y after the synchronizer latency.
        B = 1'b1;
        hold(8);
        check("alarm3_y", int'(Y), 1);
        check("alarm3_cnt", int'(ALM_CNT), 3);
        A = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            step();
            check($sformatf("disarm_edge%0d", k), int'(Y), (k == 3) ? 0 : 1);
        end
        B = 1'b0;
        hold(4);

        // All eight ABC combinations, each held 20 cycles.
        for (int abc = 0; abc < 8; abc++) begin
            {A, B, C} = 3'(abc);
            hold(20);
            check($sformatf("sweep_abc%0d", abc), int'(Y), (abc >= 5) ? 1 : 0);
            {A, B, C} = 3'b000;
            ACK = 1'b1;
            hold(6);
            ACK = 1'b0;
        end

        // 300 alarm entries saturate the counter.
        A = 1'b1;
        hold(4);
        for (int n = 0; n < 300; n++) begin
            B = (n % 2) == 0; C = (n % 3) == 0 || !B;
            hold(9);
            B = 1'b0; C = 1'b0; ACK = 1'b1;
            hold(4);
            ACK = 1'b0;
        end
        check("saturated_cnt", int'(ALM_CNT), 255);

        // Asynchronous reset while alarmed clears outputs before any clock edge.
        B = 1'b1;
        hold(8);
        check("pre_reset_y", int'(Y), 1);
        #2 rst_n = 1'b0;
        #1;
        check("async_reset_y", int'(Y), 0);
        check("async_reset_cnt", int'(ALM_CNT), 0);
        model_reset();
        hold(3);
        rst_n = 1'b1;
        hold(10);
        check("post_reset_cnt", int'(ALM_CNT), 1);
        B = 1'b0;
        hold(4);

        // Random bursty stimulus.
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(39) == 0) A = ~A;
            if ($urandom_range(7) == 0)  B = ~B;
            if ($urandom_range(9) == 0)  C = ~C;
            if ($urandom_range(5) == 0)  ACK = ~ACK;
            step();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
